// File: rtl/cplx_mac_pipe_if.sv
// cplx_mac_pipe_if: operand, product and frame-result bundle for cplx_mac_pipe
// Signals: in_valid/in_last/a_re/a_im/b_re/b_im (source -> engine);
//          prod_re/prod_im/prod_valid, acc_re/acc_im/acc_cnt/acc_ovf/acc_valid, busy (engine -> sink).
// Modports: master = sample source / result sink, slave = the engine.
interface cplx_mac_pipe_if #(
    parameter int WIDTH     = 18,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_last;
    logic signed [WIDTH-1:0]     a_re;
    logic signed [WIDTH-1:0]     a_im;
    logic signed [WIDTH-1:0]     b_re;
    logic signed [WIDTH-1:0]     b_im;
    logic signed [2*WIDTH:0]     prod_re;
    logic signed [2*WIDTH:0]     prod_im;
    logic                        prod_valid;
    logic signed [ACC_WIDTH-1:0] acc_re;
    logic signed [ACC_WIDTH-1:0] acc_im;
    logic [CNT_WIDTH-1:0]        acc_cnt;
    logic                        acc_ovf;
    logic                        acc_valid;
    logic                        busy;
    modport master (
        output in_valid, in_last, a_re, a_im, b_re, b_im,
        input  prod_re, prod_im, prod_valid, acc_re, acc_im, acc_cnt, acc_ovf, acc_valid, busy
    );
    modport slave (
        input  in_valid, in_last, a_re, a_im, b_re, b_im,
        output prod_re, prod_im, prod_valid, acc_re, acc_im, acc_cnt, acc_ovf, acc_valid, busy
    );
endinterface

// File: rtl/cplx_mac_pipe.sv
// cplx_mac_pipe: pipelined signed complex multiply (3-cycle latency) with frame accumulation
// Optional feature macro: CPLX_MAC_SAT_EN -- accumulators clamp on overflow instead of wrapping.
// Ports: clk (rising edge), rst (async, active-high), ce (freezes every register when low),
//        bus (cplx_mac_pipe_if.slave): operands/valid/last in; product, frame sum/count/overflow, busy out.
module cplx_mac_pipe #(
    parameter int WIDTH     = 18,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    cplx_mac_pipe_if.slave bus
);
    localparam int W2 = 2 * WIDTH + 1;
    typedef enum logic {IDLE, ACCUM} state_t;

    if (ACC_WIDTH < W2) begin : g_acc_width_check
        $error("cplx_mac_pipe: ACC_WIDTH must be >= 2*WIDTH+1");
    end

    logic signed [WIDTH-1:0]     r_a_re, r_a_im, r_b_re, r_b_im;
    logic signed [2*WIDTH-1:0]   r_rr, r_ii, r_ri, r_ir;
    logic signed [W2-1:0]        r_p_re, r_p_im;
    logic [2:0]                  r_v, r_l;
    state_t                      r_state, w_state_nx;
    logic signed [ACC_WIDTH-1:0] r_acc_re, r_acc_im, r_out_re, r_out_im;
    logic signed [ACC_WIDTH-1:0] w_p_re, w_p_im, w_base_re, w_base_im;
    logic signed [ACC_WIDTH-1:0] w_sum_re, w_sum_im, w_acc_re, w_acc_im;
    logic [CNT_WIDTH-1:0]        r_cnt, r_out_cnt, w_cnt;
    logic                        r_ovf, r_out_ovf, r_out_valid;
    logic                        w_ovf_re, w_ovf_im, w_ovf, w_emit;

    // S1 operands, S2 partial products, S3 complex combine; r_v/r_l carry valid and qualified last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_re <= '0;
            r_a_im <= '0;
            r_b_re <= '0;
            r_b_im <= '0;
            r_rr   <= '0;
            r_ii   <= '0;
            r_ri   <= '0;
            r_ir   <= '0;
            r_p_re <= '0;
            r_p_im <= '0;
            r_v    <= '0;
            r_l    <= '0;
        end else if (ce) begin
            r_a_re <= bus.a_re;
            r_a_im <= bus.a_im;
            r_b_re <= bus.b_re;
            r_b_im <= bus.b_im;
            r_rr   <= (2*WIDTH)'(r_a_re) * (2*WIDTH)'(r_b_re);
            r_ii   <= (2*WIDTH)'(r_a_im) * (2*WIDTH)'(r_b_im);
            r_ri   <= (2*WIDTH)'(r_a_re) * (2*WIDTH)'(r_b_im);
            r_ir   <= (2*WIDTH)'(r_a_im) * (2*WIDTH)'(r_b_re);
            r_p_re <= W2'(r_rr) - W2'(r_ii);
            r_p_im <= W2'(r_ri) + W2'(r_ir);
            r_v    <= {r_v[1:0], bus.in_valid};
            r_l    <= {r_l[1:0], bus.in_valid & bus.in_last};
        end
    end

    // A new frame (IDLE) adds the product to zero, so a frame start needs no separate load path.
    always_comb begin
        w_p_re     = ACC_WIDTH'(r_p_re);
        w_p_im     = ACC_WIDTH'(r_p_im);
        w_base_re  = (r_state == ACCUM) ? r_acc_re : '0;
        w_base_im  = (r_state == ACCUM) ? r_acc_im : '0;
        w_sum_re   = w_base_re + w_p_re;
        w_sum_im   = w_base_im + w_p_im;
        w_ovf_re   = (w_base_re[ACC_WIDTH-1] == w_p_re[ACC_WIDTH-1]) && (w_sum_re[ACC_WIDTH-1] != w_base_re[ACC_WIDTH-1]);
        w_ovf_im   = (w_base_im[ACC_WIDTH-1] == w_p_im[ACC_WIDTH-1]) && (w_sum_im[ACC_WIDTH-1] != w_base_im[ACC_WIDTH-1]);
`ifdef CPLX_MAC_SAT_EN
        w_acc_re   = w_ovf_re ? (w_base_re[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}}) : w_sum_re;
        w_acc_im   = w_ovf_im ? (w_base_im[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}}) : w_sum_im;
`else
        w_acc_re   = w_sum_re;
        w_acc_im   = w_sum_im;
`endif
        w_cnt      = (r_state == IDLE) ? CNT_WIDTH'(1) : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
        w_ovf      = ((r_state == ACCUM) && r_ovf) || w_ovf_re || w_ovf_im;
        w_emit     = r_v[2] & r_l[2];
        w_state_nx = r_v[2] ? (r_l[2] ? IDLE : ACCUM) : r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (ce) begin
            r_state     <= w_state_nx;
            r_out_valid <= w_emit;
            if (r_v[2]) begin
                r_acc_re <= w_acc_re;
                r_acc_im <= w_acc_im;
                r_cnt    <= w_cnt;
                r_ovf    <= w_ovf;
            end
            if (w_emit) begin
                r_out_re  <= w_acc_re;
                r_out_im  <= w_acc_im;
                r_out_cnt <= w_cnt;
                r_out_ovf <= w_ovf;
            end
        end
    end

    assign bus.prod_re    = r_p_re;
    assign bus.prod_im    = r_p_im;
    assign bus.prod_valid = r_v[2];
    assign bus.acc_re     = r_out_re;
    assign bus.acc_im     = r_out_im;
    assign bus.acc_cnt    = r_out_cnt;
    assign bus.acc_ovf    = r_out_ovf;
    assign bus.acc_valid  = r_out_valid;
    assign bus.busy       = (r_state == ACCUM) || (|r_v);
endmodule

// File: tb/tb_cplx_mac_pipe.sv
// tb_cplx_mac_pipe: randomized and directed checks of cplx_mac_pipe against a frame-level arithmetic model
module tb_cplx_mac_pipe;
    localparam int W = 18, AW = 37, CW = 16, W2 = 2 * W + 1;
    localparam longint AMAX  = (longint'(1) << (AW - 1)) - 1;
    localparam longint AMIN  = -(longint'(1) << (AW - 1));
    localparam longint ASPAN = longint'(1) << AW;
    localparam int CMAX = (1 << CW) - 1;
    typedef struct packed {logic signed [W2-1:0] re; logic signed [W2-1:0] im; int c;} prod_t;
    typedef struct packed {logic signed [AW-1:0] re; logic signed [AW-1:0] im; logic [CW-1:0] cnt; logic ovf; int c;} acc_t;
    logic clk = 0, rst = 1, ce = 1;
    int cyc = 0, ccyc = 0, n_vec = 0, n_err = 0;
    prod_t q_prod[$], e_prod[$], po;
    acc_t q_acc[$], e_acc[$], ao;
    int q_raw[$];
    longint m_re, m_im;
    int m_cnt;
    bit m_ovf, m_in = 0;

    cplx_mac_pipe_if #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) bus();
    cplx_mac_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .ce(ce), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ce) ccyc <= ccyc + 1;
    end
    // Record every output the downstream would consume (valid qualified by ce).
    always @(negedge clk) begin
        if (!rst && ce) begin
            if (bus.prod_valid) begin
                po.re = bus.prod_re; po.im = bus.prod_im; po.c = ccyc;
                q_prod.push_back(po);
            end
            if (bus.acc_valid) begin
                ao.re = bus.acc_re; ao.im = bus.acc_im; ao.cnt = bus.acc_cnt; ao.ovf = bus.acc_ovf; ao.c = ccyc;
                q_acc.push_back(ao);
                q_raw.push_back(cyc);
            end
        end
    end

    function automatic longint acc_add(longint a, longint b, inout bit o);
        longint s;
        s = a + b;
        if (s > AMAX || s < AMIN) begin
            o = 1;
`ifdef CPLX_MAC_SAT_EN
            s = (s > AMAX) ? AMAX : AMIN;
`else
            s = (s > AMAX) ? s - ASPAN : s + ASPAN;
`endif
        end
        return s;
    endfunction

    // Drives one cycle; a sample with ce=1 is consumed and fed to the frame model.
    task automatic drive(bit v, bit l, logic signed [W-1:0] ar, logic signed [W-1:0] ai,
                         logic signed [W-1:0] br, logic signed [W-1:0] bi, bit c);
        prod_t ep;
        acc_t ea;
        longint pr, pi;
        bit o;
        @(posedge clk); #1;
        ce = c; bus.in_valid = v; bus.in_last = l;
        bus.a_re = ar; bus.a_im = ai; bus.b_re = br; bus.b_im = bi;
        if (v && c) begin
            pr = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
            pi = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
            ep.re = W2'(pr); ep.im = W2'(pi); ep.c = ccyc + 3;
            e_prod.push_back(ep);
            if (!m_in) begin
                m_re = pr; m_im = pi; m_cnt = 1; m_ovf = 0;
            end else begin
                o = 0;
                m_re = acc_add(m_re, pr, o);
                m_im = acc_add(m_im, pi, o);
                m_ovf = m_ovf | o;
                m_cnt = (m_cnt == CMAX) ? m_cnt : m_cnt + 1;
            end
            m_in = !l;
            if (l) begin
                ea.re = AW'(m_re); ea.im = AW'(m_im); ea.cnt = CW'(m_cnt); ea.ovf = m_ovf; ea.c = ccyc + 4;
                e_acc.push_back(ea);
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic flush();
        q_prod.delete(); e_prod.delete(); q_acc.delete(); e_acc.delete(); q_raw.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.prod_valid !== 1'b0) begin n_err++; $display("FAIL reset_prod_valid: got %b want 0", bus.prod_valid); end
        n_vec++; if (bus.acc_valid !== 1'b0) begin n_err++; $display("FAIL reset_acc_valid: got %b want 0", bus.acc_valid); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++; if ({bus.acc_re, bus.acc_im, bus.acc_cnt, bus.acc_ovf} !== '0) begin n_err++; $display("FAIL reset_acc: got re=%0d im=%0d cnt=%0d ovf=%b want 0", bus.acc_re, bus.acc_im, bus.acc_cnt, bus.acc_ovf); end
        rst = 0;
    endtask

    task automatic test_single();
        prod_t ep;
        acc_t ea;
        int c0;
        drive(1, 1, 3, 4, 1, 2, 1);
        c0 = ccyc;
        idle(8);
        ep.re = W2'(-5); ep.im = W2'(10); ep.c = c0 + 3;
        ea.re = AW'(-5); ea.im = AW'(10); ea.cnt = CW'(1); ea.ovf = 0; ea.c = c0 + 4;
        n_vec++;
        if (q_prod.size() != 1 || q_acc.size() != 1) begin
            n_err++; $display("FAIL single_count: got prods=%0d accs=%0d want 1 1", q_prod.size(), q_acc.size());
        end else begin
            n_vec++; if (q_prod[0] !== ep) begin n_err++; $display("FAIL single_prod: got re=%0d im=%0d cyc=%0d want re=%0d im=%0d cyc=%0d", q_prod[0].re, q_prod[0].im, q_prod[0].c, ep.re, ep.im, ep.c); end
            n_vec++; if (q_acc[0] !== ea) begin n_err++; $display("FAIL single_acc: got re=%0d im=%0d cnt=%0d ovf=%b cyc=%0d want re=%0d im=%0d cnt=%0d ovf=%b cyc=%0d", q_acc[0].re, q_acc[0].im, q_acc[0].cnt, q_acc[0].ovf, q_acc[0].c, ea.re, ea.im, ea.cnt, ea.ovf, ea.c); end
        end
        flush();
    endtask

    task automatic test_back_to_back();
        acc_t oa, ea;
        prod_t op, ep;
        drive(1, 0, 1, 1, 1, 1, 1);
        drive(1, 0, 1, 1, 1, 1, 1);
        drive(1, 1, 1, 1, 1, 1, 1);
        drive(1, 0, 2, 0, 1, 1, 1);
        drive(1, 1, 2, 0, 1, 1, 1);
        idle(8);
        n_vec++;
        if (q_acc.size() != 2) begin
            n_err++; $display("FAIL b2b_frames: got %0d want 2", q_acc.size());
        end else begin
            n_vec++; if ({q_acc[0].re, q_acc[0].im, q_acc[0].cnt, q_acc[0].ovf} !== {AW'(0), AW'(6), CW'(3), 1'b0}) begin n_err++; $display("FAIL b2b_frame3: got re=%0d im=%0d cnt=%0d ovf=%b want 0 6 3 0", q_acc[0].re, q_acc[0].im, q_acc[0].cnt, q_acc[0].ovf); end
            n_vec++; if ({q_acc[1].re, q_acc[1].im, q_acc[1].cnt} !== {AW'(4), AW'(4), CW'(2)}) begin n_err++; $display("FAIL b2b_frame2: got re=%0d im=%0d cnt=%0d want 4 4 2", q_acc[1].re, q_acc[1].im, q_acc[1].cnt); end
        end
        n_vec++; if (q_prod.size() != e_prod.size()) begin n_err++; $display("FAIL b2b_prod_count: got %0d want %0d", q_prod.size(), e_prod.size()); end
        while (q_prod.size() > 0 && e_prod.size() > 0) begin
            op = q_prod.pop_front(); ep = e_prod.pop_front(); n_vec++;
            if (op !== ep) begin n_err++; $display("FAIL b2b_prod: got re=%0d im=%0d cyc=%0d want re=%0d im=%0d cyc=%0d", op.re, op.im, op.c, ep.re, ep.im, ep.c); end
        end
        while (q_acc.size() > 0 && e_acc.size() > 0) begin
            oa = q_acc.pop_front(); ea = e_acc.pop_front(); n_vec++;
            if (oa !== ea) begin n_err++; $display("FAIL b2b_acc: got re=%0d im=%0d cnt=%0d cyc=%0d want re=%0d im=%0d cnt=%0d cyc=%0d", oa.re, oa.im, oa.cnt, oa.c, ea.re, ea.im, ea.cnt, ea.c); end
        end
        flush();
    endtask

    task automatic test_ce_gating();
        int t0;
        drive(1, 0, 1, 1, 1, 1, 1);
        t0 = cyc;
        drive(1, 0, 1, 1, 1, 1, 0);
        drive(1, 0, 1, 1, 1, 1, 0);
        drive(1, 0, 1, 1, 1, 1, 1);
        drive(1, 1, 1, 1, 1, 1, 1);
        idle(8);
        n_vec++;
        if (q_acc.size() != 1 || q_prod.size() != 3) begin
            n_err++; $display("FAIL ce_counts: got accs=%0d prods=%0d want 1 3", q_acc.size(), q_prod.size());
        end else begin
            n_vec++; if ({q_acc[0].re, q_acc[0].im, q_acc[0].cnt} !== {AW'(0), AW'(6), CW'(3)}) begin n_err++; $display("FAIL ce_sum: got re=%0d im=%0d cnt=%0d want 0 6 3", q_acc[0].re, q_acc[0].im, q_acc[0].cnt); end
            n_vec++; if (q_raw[0] - t0 != 8) begin n_err++; $display("FAIL ce_delay: got %0d cycles want 8", q_raw[0] - t0); end
            n_vec++; if (q_acc[0] !== e_acc[0]) begin n_err++; $display("FAIL ce_model: got cyc=%0d want cyc=%0d", q_acc[0].c, e_acc[0].c); end
        end
        flush();
    endtask

    task automatic test_overflow();
        longint want;
`ifdef CPLX_MAC_SAT_EN
        want = AMAX;
`else
        want = AMIN;
`endif
        repeat (3) drive(1, 0, -131072, 0, -131072, 0, 1);
        drive(1, 1, -131072, 0, -131072, 0, 1);
        drive(1, 1, 1, 0, 1, 0, 1);
        idle(8);
        n_vec++;
        if (q_acc.size() != 2) begin
            n_err++; $display("FAIL ovf_frames: got %0d want 2", q_acc.size());
        end else begin
            n_vec++; if ({q_acc[0].re, q_acc[0].im, q_acc[0].cnt, q_acc[0].ovf} !== {AW'(want), AW'(0), CW'(4), 1'b1}) begin n_err++; $display("FAIL ovf_frame: got re=%0d im=%0d cnt=%0d ovf=%b want %0d 0 4 1", q_acc[0].re, q_acc[0].im, q_acc[0].cnt, q_acc[0].ovf, want); end
            n_vec++; if ({q_acc[1].re, q_acc[1].ovf} !== {AW'(1), 1'b0}) begin n_err++; $display("FAIL ovf_next: got re=%0d ovf=%b want 1 0", q_acc[1].re, q_acc[1].ovf); end
        end
        flush();
    endtask

    task automatic test_extremes();
        drive(1, 1, -131072, -131072, -131072, -131072, 1);
        idle(8);
        n_vec++;
        if (q_prod.size() != 1 || q_acc.size() != 1) begin
            n_err++; $display("FAIL ext_count: got prods=%0d accs=%0d want 1 1", q_prod.size(), q_acc.size());
        end else begin
            n_vec++; if ({q_prod[0].re, q_prod[0].im} !== {W2'(0), W2'(longint'(1) << 35)}) begin n_err++; $display("FAIL ext_prod: got re=%0d im=%0d want 0 %0d", q_prod[0].re, q_prod[0].im, longint'(1) << 35); end
            n_vec++; if ({q_acc[0].re, q_acc[0].im, q_acc[0].ovf} !== {AW'(0), AW'(longint'(1) << 35), 1'b0}) begin n_err++; $display("FAIL ext_acc: got re=%0d im=%0d ovf=%b want 0 %0d 0", q_acc[0].re, q_acc[0].im, q_acc[0].ovf, longint'(1) << 35); end
        end
        flush();
    endtask

    task automatic test_reset_midframe();
        drive(1, 0, 5, 1, 2, 3, 1);
        drive(1, 0, 7, 2, 1, 4, 1);
        idle(2);
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b want 1", bus.busy); end
        rst = 1;
        #1;
        n_vec++; if ({bus.prod_valid, bus.acc_valid, bus.busy} !== 3'b000) begin n_err++; $display("FAIL rmid_flags: got pv=%b av=%b busy=%b want 0 0 0", bus.prod_valid, bus.acc_valid, bus.busy); end
        n_vec++; if ({bus.acc_re, bus.acc_im, bus.acc_cnt, bus.prod_re, bus.prod_im} !== '0) begin n_err++; $display("FAIL rmid_data: got acc=%0d+j%0d cnt=%0d prod=%0d+j%0d want 0", bus.acc_re, bus.acc_im, bus.acc_cnt, bus.prod_re, bus.prod_im); end
        @(posedge clk); #1;
        rst = 0;
        n_vec++; if (q_acc.size() != 0) begin n_err++; $display("FAIL rmid_no_emit: got %0d want 0", q_acc.size()); end
        m_in = 0;
        flush();
        drive(1, 1, 2, 0, 3, 0, 1);
        idle(8);
        n_vec++;
        if (q_acc.size() != 1) begin
            n_err++; $display("FAIL rmid_next_count: got %0d want 1", q_acc.size());
        end else if ({q_acc[0].re, q_acc[0].im, q_acc[0].cnt, q_acc[0].ovf} !== {AW'(6), AW'(0), CW'(1), 1'b0}) begin
            n_err++; $display("FAIL rmid_next: got re=%0d im=%0d cnt=%0d ovf=%b want 6 0 1 0", q_acc[0].re, q_acc[0].im, q_acc[0].cnt, q_acc[0].ovf);
        end
        flush();
    endtask

    task automatic test_random();
        prod_t op, ep;
        acc_t oa, ea;
        for (int f = 0; f < 12; f++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int s = 0; s < len; s++) begin
                logic signed [W-1:0] ar, ai, br, bi;
                ar = W'($urandom); ai = W'($urandom); br = W'($urandom); bi = W'($urandom);
                if ($urandom_range(0, 3) == 0) drive(0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) drive(1, s == len - 1, ar, ai, br, bi, 0);
                drive(1, s == len - 1, ar, ai, br, bi, 1);
            end
        end
        idle(10);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rand_busy_end: got %b want 0", bus.busy); end
        n_vec++; if (q_prod.size() != e_prod.size() || q_acc.size() != e_acc.size()) begin n_err++; $display("FAIL rand_counts: got prods=%0d accs=%0d want %0d %0d", q_prod.size(), q_acc.size(), e_prod.size(), e_acc.size()); end
        while (q_prod.size() > 0 && e_prod.size() > 0) begin
            op = q_prod.pop_front(); ep = e_prod.pop_front(); n_vec++;
            if (op !== ep) begin n_err++; $display("FAIL rand_prod: got re=%0d im=%0d cyc=%0d want re=%0d im=%0d cyc=%0d", op.re, op.im, op.c, ep.re, ep.im, ep.c); end
        end
        while (q_acc.size() > 0 && e_acc.size() > 0) begin
            oa = q_acc.pop_front(); ea = e_acc.pop_front(); n_vec++;
            if (oa !== ea) begin n_err++; $display("FAIL rand_acc: got re=%0d im=%0d cnt=%0d ovf=%b cyc=%0d want re=%0d im=%0d cnt=%0d ovf=%b cyc=%0d", oa.re, oa.im, oa.cnt, oa.ovf, oa.c, ea.re, ea.im, ea.cnt, ea.ovf, ea.c); end
        end
        flush();
    endtask

    initial begin
        bus.in_valid = 0; bus.in_last = 0;
        bus.a_re = 0; bus.a_im = 0; bus.b_re = 0; bus.b_im = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_ce_gating();
        test_overflow();
        test_extremes();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cplx_mac_pipe.md
Name: cplx_mac_pipe

Overview:
- Parametrised, pipelined complex multiply-accumulate engine; successor to the fixed-width adder/multiplier chains in the arithmetic datapath.
- Computes P = A·B for signed complex operands every cycle, with valid and last handshake.
- Accumulates products over a frame delimited by in_last, then emits the frame sum, the sample count and an overflow flag.
- Sits between sample sources (filters, correlators) and downstream magnitude/decision logic.

Parameters:
WIDTH, 18, signed bit width of each operand component (re/im).
ACC_WIDTH, 48, signed accumulator width per component; must be >= 2*WIDTH+1 (elaboration error otherwise).
CNT_WIDTH, 16, width of frame sample counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
ce  input  1  clock enable; low freezes every register in the block
in_valid  input  1  operand strobe
in_last  input  1  marks final sample of frame; ignored unless in_valid=1
a_re, a_im  input  WIDTH each  operand A, two's complement
b_re, b_im  input  WIDTH each  operand B, two's complement
prod_re, prod_im  output  2*WIDTH+1 each  product P
prod_valid  output  1  P valid
acc_re, acc_im  output  ACC_WIDTH each  frame sum
acc_cnt  output  CNT_WIDTH  samples in emitted frame
acc_ovf  output  1  frame overflowed (see below)
acc_valid  output  1  frame result valid
busy  output  1  frame in progress (FSM in ACCUM or data in pipe)

Behaviour:
- Reset (async, rst=1): all pipeline data, valid/last flags, accumulators, counters, outputs = 0; FSM = IDLE. rst mid-frame discards the partial frame; no acc_valid produced.
- All registers advance only when ce=1; with ce=0 outputs hold. A held valid strobe counts once; downstream qualifies valid with ce.
- Pipeline (ce=1 throughout), with W2 = 2*WIDTH+1 and operands sign-extended:
  - S1: register operands, valid, last.
  - S2: four signed products rr=a_re·b_re, ii=a_im·b_im, ri=a_re·b_im, ir=a_im·b_re.
  - S3: prod_re=rr−ii, prod_im=ri+ir, exact in W2 bits, no overflow.
  - Latency in_valid→prod_valid = 3 cycles; throughput 1 sample/cycle; no backpressure.
- Accumulator FSM, states IDLE and ACCUM, driven by S3 outputs (prod_valid, last3):
  - IDLE & prod_valid & !last3: acc ← sext(P), cnt ← 1, ovf ← 0 → ACCUM.
  - IDLE & prod_valid & last3: single-sample frame; result = sext(P), cnt 1, ovf 0; stay IDLE.
  - ACCUM & prod_valid: acc ← acc + sext(P), cnt ← cnt+1 (saturates at 2^CNT_WIDTH−1); if last3, emit and → IDLE.
  - No prod_valid: state and acc hold.
- Emit: acc_re/acc_im/acc_cnt/acc_ovf registered; acc_valid=1 for the one ce cycle after the last product, i.e. 4 cycles after the in_last sample. Outputs hold until the next emit.
- Back-to-back frames (last followed immediately by new valid): no bubble; the new frame starts in IDLE the next cycle.
- Overflow: per component, signed add overflow detected (operand signs equal, result sign differs). acc_ovf is sticky within the frame, OR of re and im, and cleared at frame start.

Optional Feature:
CPLX_MAC_SAT_EN
- Defined: on overflow, the accumulator component clamps to +2^(ACC_WIDTH−1)−1 or −2^(ACC_WIDTH−1), following the operand sign, and stays clamped-arithmetic thereafter. acc_ovf is still set.
- Undefined: two's-complement wrap; acc_ovf set.
- Pipeline and latency are identical either way.

Test Plan:
- Single product: A=3+j4, B=1+j2, last=1, ce=1 → cycle+3 prod=−5+j10, prod_valid=1; cycle+4 acc=−5+j10, cnt=1, ovf=0, acc_valid=1.
- Frame of 3: A=B=1+j1 on 3 consecutive cycles, last on 3rd → prods 0+j2 ×3; acc=0+j6, cnt=3, single acc_valid pulse; a new frame starting the next cycle yields an independent result.
- ce gating: same 3-sample frame with ce low for 2 cycles mid-stream → identical sums; acc_valid delayed by exactly 2 cycles; no duplicated samples.
- Overflow (WIDTH=18, ACC_WIDTH=37): 4 samples A=B=−131072+j0 (prod_re=2^34) → macro off: acc_re=−2^36, ovf=1; CPLX_MAC_SAT_EN: acc_re=68719476735, ovf=1; next frame ovf=0.
- Extremes: A=B=−131072−j131072 → prod_re=0, prod_im=2^35; no truncation in 37 bits.
- Reset mid-frame: assert rst after 2 samples of a 4-sample frame → outputs 0 immediately, busy=0, no acc_valid; next 1-sample frame 2+j0·3+j0 → acc=6, cnt=1.
